// File: rtl/apb_master_bridge.sv
// Bridges a valid/ready command channel to single APB transfers and returns
// each result on a valid/ready response channel; a watchdog aborts stuck slaves.
module apb_master_bridge #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned TO_CNT_W    = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam bit                  WD_EN   = (TIMEOUT_CYC != 0);
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(WD_EN ? TIMEOUT_CYC - 1 : 0);

  state_t              state_q, state_d;
  logic [TO_CNT_W-1:0] to_cnt_q;
  logic                wd_fire;
  logic                cmd_ready_q;

  always_comb begin
    state_d = state_q;
    wd_fire = 1'b0;
    case (state_q)
      IDLE:   if (cmd_valid) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          state_d = RESP;
        end else if (WD_EN && (to_cnt_q == TO_LAST)) begin
          // counter holds completed wait cycles, so this is the last allowed one
          wd_fire = 1'b1;
          state_d = RESP;
        end
      end
      RESP:   if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      to_cnt_q    <= '0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == IDLE);
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            pwrite   <= cmd_write;
            paddr    <= cmd_addr;
            pwdata   <= cmd_write ? cmd_wdata : '0;
            to_cnt_q <= '0;
          end
        end
        ACCESS: begin
          if (pready) begin
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_slverr  <= pslverr;
            rsp_timeout <= 1'b0;
          end else if (wd_fire) begin
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // cmd_ready is registered so it stays low while reset is asserted
  assign cmd_ready = cmd_ready_q && (state_q == IDLE);
  assign psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable   = (state_q == ACCESS);
  assign rsp_valid = (state_q == RESP);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: a bench-side APB slave plus a
// transaction-level model predicting each transfer's timing and response.
module tb_apb_master_bridge;

  localparam int TO = 16;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr, rsp_timeout;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0, pslverr = 1'b0;

  apb_master_bridge #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYC(TO), .TO_CNT_W(8)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int n_chk = 0, n_err = 0, cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Plan for the current transfer: wait states before pready, and error flag
  int unsigned plan_w = 0;
  bit          plan_err = 0;

  logic [31:0] slv_mem [0:255];
  logic [31:0] mdl_mem [0:255];

  // APB slave: garbage outside ACCESS, pready after plan_w wait cycles
  int unsigned acc_k = 0;
  always @(negedge pclk) begin
    if (psel && penable) begin
      if (acc_k == plan_w) begin
        pready  = 1'b1;
        pslverr = plan_err;
        prdata  = pwrite ? $urandom : slv_mem[paddr];
        if (pwrite && !plan_err) slv_mem[paddr] = pwdata;
      end else begin
        pready  = 1'b0;
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end
      acc_k++;
    end else begin
      acc_k   = 0;
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      prdata  = $urandom;
    end
  end

  // Transaction-level model and per-cycle compare
  bit          checking = 0, busy = 0;
  int          acc_a, len;
  bit          e_wr, e_se, e_to;
  logic [7:0]  e_addr;
  logic [31:0] e_pwdata, e_rd;

  always @(negedge pclk) begin
    if (!checking) begin
      busy = 0;
    end else if (!busy) begin
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_psel", psel, 0);
      chk("idle_penable", penable, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      if (cmd_valid) begin
        busy     = 1;
        acc_a    = cyc;
        e_wr     = cmd_write;
        e_addr   = cmd_addr;
        e_pwdata = cmd_write ? cmd_wdata : 32'h0;
        if (plan_w >= TO) begin
          len = TO; e_rd = 0; e_se = 1; e_to = 1;
        end else begin
          len  = int'(plan_w) + 1;
          e_se = plan_err; e_to = 0;
          e_rd = cmd_write ? 32'h0 : mdl_mem[cmd_addr];
          if (cmd_write && !plan_err) mdl_mem[cmd_addr] = cmd_wdata;
        end
      end
    end else begin
      int d;
      d = cyc - acc_a;
      chk("busy_cmd_ready", cmd_ready, 0);
      if (d <= 1 + len) begin
        chk("apb_psel", psel, 1);
        chk("apb_penable", penable, (d >= 2) ? 1 : 0);
        chk("apb_pwrite", pwrite, e_wr);
        chk("apb_paddr", paddr, e_addr);
        chk("apb_pwdata", pwdata, e_pwdata);
        chk("apb_rsp_valid", rsp_valid, 0);
      end else begin
        chk("rsp_psel", psel, 0);
        chk("rsp_penable", penable, 0);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("rsp_slverr", rsp_slverr, e_se);
        chk("rsp_timeout", rsp_timeout, e_to);
        if (rsp_ready) busy = 0;
      end
    end
  end

  // bp<0: random rsp_ready; bp>=0: hold rsp_ready low for bp response cycles
  task automatic issue(input bit wr, input logic [7:0] a, input logic [31:0] d,
                       input int unsigned w, input bit e, input int bp,
                       output logic [31:0] rd, output bit se, output bit to,
                       output int lat, output int acc);
    bit got = 0, seen = 0;
    int nheld = 0;
    rd = '0; se = 0; to = 0; lat = -1; acc = -1;
    plan_w = w; plan_err = e;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1; rsp_ready = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge pclk);
      if (cmd_ready) begin got = 1; acc = cyc; end
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL accept_wait: got no cmd_ready expected 1 within 50 cycles");
      return;
    end
    @(posedge pclk); #1;
    got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      if (bp < 0) rsp_ready = ($urandom % 3) != 0;
      else        rsp_ready = (bp == 0) || (nheld >= bp);
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
      cmd_addr = 8'($urandom); cmd_wdata = $urandom;
      @(negedge pclk);
      if (rsp_valid && !seen) begin seen = 1; lat = n + 1; end
      if (rsp_valid && rsp_ready) begin
        rd = rsp_rdata; se = rsp_slverr; to = rsp_timeout; got = 1;
      end else begin
        if (rsp_valid) nheld++;
        @(posedge pclk); #1;
      end
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL response_wait: got no response expected one within 200 cycles");
    end
    @(posedge pclk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish by 400us");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    bit se, to;
    int lat, a1, a2;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = $urandom;
      slv_mem[i] = v;
      mdl_mem[i] = v;
    end
    repeat (3) @(posedge pclk);
    #1;
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_psel", psel, 0);
    chk("reset_penable", penable, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_paddr", paddr, 0);
    chk("reset_pwdata", pwdata, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    presetn = 1'b1;
    @(posedge pclk); #1;
    checking = 1;

    issue(1, 8'h10, 32'hDEADBEEF, 0, 0, 0, rd, se, to, lat, a1);
    chk("wr_lat", lat, 3);
    chk("wr_rdata", rd, 0);
    chk("wr_slverr", se, 0);
    chk("wr_timeout", to, 0);
    issue(0, 8'h10, 32'hFFFFFFFF, 0, 0, 0, rd, se, to, lat, a2);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_lat", lat, 3);
    chk("throughput", a2 - a1, 4);
    issue(1, 8'h20, 32'h12345678, 3, 0, 0, rd, se, to, lat, a1);
    chk("wait3_lat", lat, 6);
    issue(0, 8'h20, 32'h0, 0, 1, 0, rd, se, to, lat, a1);
    chk("err_slverr", se, 1);
    chk("err_timeout", to, 0);
    chk("err_rdata", rd, 32'h12345678);
    issue(0, 8'h20, 32'h0, 16, 0, 0, rd, se, to, lat, a1);
    chk("to_lat", lat, 18);
    chk("to_slverr", se, 1);
    chk("to_timeout", to, 1);
    chk("to_rdata", rd, 0);
    issue(0, 8'h20, 32'h0, 15, 0, 0, rd, se, to, lat, a1);
    chk("w15_lat", lat, 18);
    chk("w15_timeout", to, 0);
    chk("w15_rdata", rd, 32'h12345678);
    issue(1, 8'h30, 32'hCAFEF00D, 0, 0, 5, rd, se, to, lat, a1);
    chk("bp_lat", lat, 3);
    chk("bp_slverr", se, 0);

    for (int t = 0; t < 60; t++) begin
      int unsigned r, w;
      r = $urandom % 10;
      w = (r < 6) ? 0 : (r < 9) ? ($urandom % 4) : (14 + $urandom % 6);
      issue(1'($urandom), 8'($urandom % 16), $urandom, w, ($urandom % 6) == 0, -1,
            rd, se, to, lat, a1);
    end

    // Reset during ACCESS of a stuck transfer
    checking = 0;
    plan_w = 100; plan_err = 0;
    cmd_write = 1'b0; cmd_addr = 8'h10; cmd_valid = 1'b1;
    @(negedge pclk);
    chk("mid_accept_ready", cmd_ready, 1);
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    chk("mid_in_access", penable, 1);
    presetn = 1'b0;
    #1;
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_psel", psel, 0);
    @(posedge pclk); #1;
    checking = 1;

    issue(0, 8'h10, 32'h0, 1, 0, -1, rd, se, to, lat, a1);
    chk("final_rd_data", rd, 32'hDEADBEEF);
    chk("final_rd_lat", lat, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
